soc_io_bridge: RTL

//  Memory-mapped IO page for the step-13+ SOC. Decodes CPU accesses with io_addr[IO_ADDR_BIT]=1.

---
 rtl/soc_io_bridge_pkg.sv | 18 +
 rtl/soc_io_bridge_uart_tx_core.sv | 96 +++++++++
 rtl/soc_io_bridge.sv | 115 +++++++++++
 3 files changed

// File: rtl/soc_io_bridge_pkg.sv
// rtl/soc_io_bridge_pkg.sv - shared IO page register indices, CNTL bit positions and TX FSM states
package soc_io_bridge_pkg;

    localparam int REG_LEDS_BIT  = 2;
    localparam int REG_DAT_BIT   = 3;
    localparam int REG_CNTL_BIT  = 4;

    localparam int CNTL_BUSY_BIT = 9;
    localparam int CNTL_OVF_BIT  = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/soc_io_bridge_uart_tx_core.sv
// rtl/soc_io_bridge_uart_tx_core.sv - UART 8N1 transmitter core, each bit held for DIV clocks
module uart_tx_core
    import soc_io_bridge_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t      state, state_nx;
    logic [CW-1:0]  div_cnt, div_nx;
    logic [2:0]     bit_cnt, bit_nx;
    logic [7:0]     shift, shift_nx;
    logic           txd_nx;
    logic           bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
            txd     <= txd_nx;
        end
    end

    assign bit_end = (div_cnt == CW'(DIV - 1));
    assign ready   = (state == TX_IDLE);

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        txd_nx   = txd;
        case (state)
            TX_IDLE: begin
                if (valid) begin
                    state_nx = TX_START;
                    div_nx   = '0;
                    bit_nx   = '0;
                    shift_nx = data;
                    txd_nx   = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    div_nx   = '0;
                    state_nx = TX_DATA;
                    txd_nx   = shift[0];
                    shift_nx = shift >> 1;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    div_nx = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nx = TX_STOP;
                        txd_nx   = 1'b1;
                    end else begin
                        bit_nx   = bit_cnt + 3'd1;
                        txd_nx   = shift[0];
                        shift_nx = shift >> 1;
                    end
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    div_nx   = '0;
                    state_nx = TX_IDLE;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/soc_io_bridge.sv
// rtl/soc_io_bridge.sv - IO page: LED register, UART TX data/status; SOC_IO_TXFIFO_EN adds a TX FIFO
module soc_io_bridge
    import soc_io_bridge_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25_000_000,
    parameter int BAUD         = 115_200,
    parameter int LED_W        = 8,
    parameter int IO_ADDR_BIT  = 22,
    parameter int TXFIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      io_addr,
    input  logic [31:0]      io_wdata,
    input  logic             io_wstrb,
    input  logic             io_rstrb,
    output logic [31:0]      io_rdata,
    output logic [LED_W-1:0] led,
    output logic             uart_txd
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;

    logic        sel, hot_leds, hot_dat, hot_cntl;
    logic        wr_dat, rd_cntl;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        drop, status_bit, ovf;
    logic [31:0] cntl_val, rd_val;
    logic        unused_bits;

    assign sel      = io_addr[IO_ADDR_BIT];
    assign hot_leds = sel & io_addr[REG_LEDS_BIT];
    assign hot_dat  = sel & io_addr[REG_DAT_BIT];
    assign hot_cntl = sel & io_addr[REG_CNTL_BIT];
    assign wr_dat   = io_wstrb & hot_dat;
    assign rd_cntl  = io_rstrb & hot_cntl;

    assign unused_bits = ^{io_addr, io_wdata};

`ifdef SOC_IO_TXFIFO_EN
    localparam int AW = (TXFIFO_DEPTH > 1) ? $clog2(TXFIFO_DEPTH) : 1;

    logic [7:0]  fifo_mem [TXFIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok;

    assign full     = (count == (AW+1)'(TXFIFO_DEPTH));
    assign tx_valid = (count != '0);
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign push_ok  = wr_dat & (~full | pop);
    assign drop     = wr_dat & ~push_ok;
    assign status_bit = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= io_wdata[7:0];
    end
`else
    localparam int unused_depth = TXFIFO_DEPTH;

    assign tx_valid   = wr_dat;
    assign tx_data    = io_wdata[7:0];
    assign drop       = wr_dat & ~tx_ready;
    assign status_bit = ~tx_ready;
`endif

    uart_tx_core #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .txd   (uart_txd)
    );

    always_comb begin
        cntl_val = '0;
        cntl_val[CNTL_BUSY_BIT] = status_bit;
        cntl_val[CNTL_OVF_BIT]  = ovf;
        rd_val = '0;
        if (hot_leds) rd_val = rd_val | 32'(led);
        if (hot_cntl) rd_val = rd_val | cntl_val;
    end

    // A fresh overflow wins over the clearing read so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= '0;
            io_rdata <= '0;
            ovf      <= 1'b0;
        end else begin
            if (io_wstrb && hot_leds) led <= io_wdata[LED_W-1:0];
            if (io_rstrb)             io_rdata <= rd_val;
            if (drop)                 ovf <= 1'b1;
            else if (rd_cntl)         ovf <= 1'b0;
        end
    end

endmodule
